ip_payload_dispatcher: RTL and testbench

Parametrised dispatcher between the IP decoder and the transport-layer decoders. It buffers the IP payload word stream in a FIFO and selects one of `N_CH` downstream channels from a protocol-number table. It forwards words to that channel under a ready/start handshake, then merges the IP and channel results into one `ok`/`fin` per packet. A completion timeout guards against a downstream decoder that never finishes.

---
 rtl/ip_payload_dispatcher_if.sv | 14 +
 rtl/ip_payload_dispatcher.sv | 121 ++++++++++++
 tb/tb_ip_payload_dispatcher.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ip_payload_dispatcher_if.sv
// ip_payload_dispatcher_if: downstream channel bus between the dispatcher and the transport decoders
interface ip_payload_dispatcher_if #(
  parameter int N_CH = 2,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0] ch_ready;
  logic [N_CH-1:0] ch_ok;
  logic [N_CH-1:0] ch_fin;
  logic [N_CH-1:0] ch_start;
  logic [DATA_W-1:0] ch_data;
  logic [15:0] ch_len;
  modport master (input ch_ready, ch_ok, ch_fin, output ch_start, ch_data, ch_len);
  modport slave (output ch_ready, ch_ok, ch_fin, input ch_start, ch_data, ch_len);
endinterface

// File: rtl/ip_payload_dispatcher.sv
// ip_payload_dispatcher: buffers IP payload words and routes them to a protocol-selected transport decoder
module ip_payload_dispatcher #(
  parameter int N_CH = 2,
  parameter logic [N_CH*8-1:0] PROTO_TABLE = {8'd17, 8'd6},
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] protocol,
  input  logic [15:0] len_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic wr_en_in,
  input  logic ok_in,
  input  logic fin_in,
  ip_payload_dispatcher_if.master ch,
  output logic ok,
  output logic fin,
  output logic busy,
  output logic [15:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, ROUTE = 3'd1, DRAIN = 3'd2, WAIT_CH = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [SW-1:0] sel, m_sel;
  logic hit, m_hit, ovf, ok_lat, res;
  logic [TW-1:0] timer;
  logic [15:0] len_q;
  logic accept, full, push, pop, drop, live;
  always_comb begin
    m_hit = 1'b0;
    m_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (PROTO_TABLE[8*i +: 8] == protocol) begin
        m_hit = 1'b1;
        m_sel = SW'(i);
      end
  end
  always_comb begin
    accept = wr_en_in && (state == IDLE || state == ROUTE);
    full = count == (AW+1)'(DEPTH);
    push = accept && !full;
    drop = wr_en_in && !push;
    live = count != '0;
    pop = live && (!hit || ch.ch_ready[sel]);
  end
  assign ch.ch_start = hit && live ? N_CH'(1) << sel : '0;
  assign ch.ch_data = hit && live ? mem[rd_ptr] : '0;
  assign ch.ch_len = len_q;
  assign fin = state == DONE;
  assign ok = fin && res;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      sel <= '0;
      hit <= 1'b0;
      ovf <= 1'b0;
      ok_lat <= 1'b0;
      res <= 1'b0;
      timer <= '0;
      len_q <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (accept && full) ovf <= 1'b1;
      case (state)
        IDLE:
          if (wr_en_in) begin
            len_q <= len_in;
            sel <= m_sel;
            hit <= m_hit;
            ok_lat <= ok_in;
            state <= fin_in ? DRAIN : ROUTE;
          end else if (fin_in) begin
            res <= ok_in && !m_hit;
            state <= DONE;
          end
        ROUTE:
          if (fin_in) begin
            ok_lat <= ok_in;
            state <= DRAIN;
          end
        DRAIN:
          if (!live) begin
            timer <= TW'(TIMEOUT);
            res <= ok_lat && !ovf;
            state <= hit ? WAIT_CH : DONE;
          end
        WAIT_CH:
          if (ch.ch_fin[sel]) begin
            res <= ok_lat && ch.ch_ok[sel] && !ovf;
            state <= DONE;
          end else if (timer == '0) begin
            res <= 1'b0;
            state <= DONE;
          end else timer <= timer - TW'(1);
        DONE: begin
          ovf <= 1'b0;
          hit <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_payload_dispatcher.sv
// tb_ip_payload_dispatcher: directed scenario tests for ip_payload_dispatcher (ch0 = UDP 17, ch1 = TCP 6)
module tb_ip_payload_dispatcher;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] protocol;
  logic [15:0] len_in;
  logic [31:0] data_in;
  logic wr_en_in, ok_in, fin_in;
  logic ok, fin, busy;
  logic [15:0] drop_cnt;
  int total = 0;
  int bad = 0;
  ip_payload_dispatcher_if #(.N_CH(2), .DATA_W(32)) chif ();
  ip_payload_dispatcher #(
    .N_CH(2), .PROTO_TABLE({8'd6, 8'd17}), .DATA_W(32), .DEPTH(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .protocol(protocol), .len_in(len_in), .data_in(data_in),
    .wr_en_in(wr_en_in), .ok_in(ok_in), .fin_in(fin_in), .ch(chif),
    .ok(ok), .fin(fin), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic clear_in();
    wr_en_in = 1'b0;
    fin_in = 1'b0;
    chif.ch_fin = 2'b00;
    chif.ch_ok = 2'b00;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fin !== 1'b0 || ok !== 1'b0) begin bad++; $display("FAIL reset_fin_ok: got fin=%b ok=%b want 0 0", fin, ok); end
    total++; if (chif.ch_start !== 2'b00 || chif.ch_data !== 32'h0) begin bad++; $display("FAIL reset_ch: got start=%b data=%h want 00 0", chif.ch_start, chif.ch_data); end
    total++; if (chif.ch_len !== 16'h0 || drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_len_drop: got len=%h drop=%h want 0 0", chif.ch_len, drop_cnt); end
  endtask
  task automatic test_tcp();
    protocol = 8'd6; len_in = 16'd16; ok_in = 1'b1; chif.ch_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hA0 + i; wr_en_in = 1'b1; fin_in = i == 3;
      cyc();
      total++;
      if (chif.ch_start !== 2'b10 || chif.ch_data !== 32'hA0 + i) begin
        bad++; $display("FAIL tcp_word%0d: got start=%b data=%h want 10 %h", i, chif.ch_start, chif.ch_data, 32'hA0 + i);
      end
    end
    clear_in();
    total++; if (chif.ch_len !== 16'd16) begin bad++; $display("FAIL tcp_len: got %0d want 16", chif.ch_len); end
    cyc();
    total++; if (chif.ch_start !== 2'b00 || fin !== 1'b0) begin bad++; $display("FAIL tcp_drained: got start=%b fin=%b want 00 0", chif.ch_start, fin); end
    cyc();
    chif.ch_fin = 2'b10; chif.ch_ok = 2'b10;
    cyc();
    total++; if (fin !== 1'b1 || ok !== 1'b1) begin bad++; $display("FAIL tcp_done: got fin=%b ok=%b want 1 1", fin, ok); end
    clear_in();
    cyc();
    total++; if (fin !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL tcp_idle: got fin=%b busy=%b want 0 0", fin, busy); end
  endtask
  task automatic test_udp_backpressure();
    int k;
    logic stall;
    logic [31:0] pdata;
    k = 0; stall = 1'b0; pdata = '0;
    protocol = 8'd17; len_in = 16'd24; ok_in = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      wr_en_in = c < 6; data_in = 32'hB0 + c; fin_in = c == 5;
      chif.ch_ready = {1'b1, c[0]};
      if (stall) begin
        total++;
        if (chif.ch_start !== 2'b01 || chif.ch_data !== pdata) begin
          bad++; $display("FAIL udp_hold: got start=%b data=%h want 01 %h", chif.ch_start, chif.ch_data, pdata);
        end
      end
      if (chif.ch_start === 2'b01 && chif.ch_ready[0]) begin
        total++;
        if (chif.ch_data !== 32'hB0 + k) begin bad++; $display("FAIL udp_word%0d: got %h want %h", k, chif.ch_data, 32'hB0 + k); end
        k++;
      end
      stall = chif.ch_start === 2'b01 && !chif.ch_ready[0];
      pdata = chif.ch_data;
      cyc();
    end
    clear_in();
    total++; if (k != 6) begin bad++; $display("FAIL udp_count: got %0d words want 6", k); end
    cyc();
    chif.ch_fin = 2'b01; chif.ch_ok = 2'b01;
    cyc();
    total++; if (fin !== 1'b1 || ok !== 1'b1) begin bad++; $display("FAIL udp_done: got fin=%b ok=%b want 1 1", fin, ok); end
    clear_in();
    cyc();
  endtask
  task automatic test_unmatched();
    protocol = 8'd1; len_in = 16'd12; ok_in = 1'b1; chif.ch_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hC0 + i; wr_en_in = 1'b1; fin_in = i == 2;
      cyc();
      total++; if (chif.ch_start !== 2'b00) begin bad++; $display("FAIL unm_start%0d: got %b want 00", i, chif.ch_start); end
    end
    clear_in();
    cyc();
    total++; if (fin !== 1'b0 || chif.ch_start !== 2'b00) begin bad++; $display("FAIL unm_drain: got fin=%b start=%b want 0 00", fin, chif.ch_start); end
    cyc();
    total++; if (fin !== 1'b1 || ok !== 1'b1) begin bad++; $display("FAIL unm_done: got fin=%b ok=%b want 1 1", fin, ok); end
    cyc();
    total++; if (fin !== 1'b0 || ok !== 1'b0) begin bad++; $display("FAIL unm_pulse: got fin=%b ok=%b want 0 0", fin, ok); end
  endtask
  task automatic test_overflow();
    int k;
    k = 0;
    protocol = 8'd6; len_in = 16'd40; ok_in = 1'b1; chif.ch_ready = 2'b00;
    for (int i = 0; i < 10; i++) begin
      data_in = 32'hD0 + i; wr_en_in = 1'b1; fin_in = i == 9;
      cyc();
    end
    clear_in();
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
    chif.ch_ready = 2'b11;
    for (int c = 0; c < 20 && k < 8; c++) begin
      if (chif.ch_start === 2'b10) begin
        total++;
        if (chif.ch_data !== 32'hD0 + k) begin bad++; $display("FAIL ovf_word%0d: got %h want %h", k, chif.ch_data, 32'hD0 + k); end
        k++;
      end
      cyc();
    end
    total++; if (k != 8 || chif.ch_start !== 2'b00) begin bad++; $display("FAIL ovf_count: got %0d words start=%b want 8 00", k, chif.ch_start); end
    cyc();
    chif.ch_fin = 2'b10; chif.ch_ok = 2'b10;
    cyc();
    total++; if (fin !== 1'b1 || ok !== 1'b0) begin bad++; $display("FAIL ovf_done: got fin=%b ok=%b want 1 0", fin, ok); end
    clear_in();
    cyc();
  endtask
  task automatic test_timeout();
    protocol = 8'd6; len_in = 16'd4; ok_in = 1'b1; chif.ch_ready = 2'b11;
    data_in = 32'hE0; wr_en_in = 1'b1; fin_in = 1'b1;
    cyc();
    clear_in();
    total++; if (chif.ch_start !== 2'b10 || chif.ch_data !== 32'hE0) begin bad++; $display("FAIL to_word: got start=%b data=%h want 10 e0", chif.ch_start, chif.ch_data); end
    for (int i = 2; i <= 19; i++) begin
      cyc();
      total++; if (fin !== 1'b0) begin bad++; $display("FAIL to_early: fin high at cycle %0d want 0", i); end
    end
    cyc();
    total++; if (fin !== 1'b1 || ok !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_fin: got fin=%b ok=%b busy=%b want 1 0 1", fin, ok, busy); end
    cyc();
    total++; if (busy !== 1'b0 || fin !== 1'b0) begin bad++; $display("FAIL to_idle: got busy=%b fin=%b want 0 0", busy, fin); end
  endtask
  task automatic test_reset_mid();
    protocol = 8'd6; len_in = 16'd8; ok_in = 1'b1; chif.ch_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      data_in = 32'h70 + i; wr_en_in = 1'b1;
      cyc();
    end
    wr_en_in = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++; if (busy !== 1'b0 || fin !== 1'b0 || drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_state: got busy=%b fin=%b drop=%0d want 0 0 0", busy, fin, drop_cnt); end
    total++; if (chif.ch_start !== 2'b00 || chif.ch_data !== 32'h0 || chif.ch_len !== 16'h0) begin bad++; $display("FAIL rst_mid_ch: got start=%b data=%h len=%h want 00 0 0", chif.ch_start, chif.ch_data, chif.ch_len); end
    protocol = 8'd17; len_in = 16'd4; chif.ch_ready = 2'b11;
    data_in = 32'hF0; wr_en_in = 1'b1; fin_in = 1'b1;
    cyc();
    clear_in();
    total++; if (chif.ch_start !== 2'b01 || chif.ch_data !== 32'hF0 || chif.ch_len !== 16'd4) begin bad++; $display("FAIL rst_new_word: got start=%b data=%h len=%0d want 01 f0 4", chif.ch_start, chif.ch_data, chif.ch_len); end
    cyc();
    cyc();
    wr_en_in = 1'b1; data_in = 32'h99;
    total++; if (fin !== 1'b0) begin bad++; $display("FAIL rst_no_fin: got fin=%b want 0", fin); end
    cyc();
    wr_en_in = 1'b0;
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL busy_drop: got %0d want 1", drop_cnt); end
    chif.ch_fin = 2'b01; chif.ch_ok = 2'b01;
    cyc();
    total++; if (fin !== 1'b1 || ok !== 1'b1) begin bad++; $display("FAIL rst_new_done: got fin=%b ok=%b want 1 1", fin, ok); end
    clear_in();
    cyc();
    total++; if (busy !== 1'b0 || fin !== 1'b0) begin bad++; $display("FAIL rst_new_idle: got busy=%b fin=%b want 0 0", busy, fin); end
  endtask
  initial begin
    reset = 1'b1; protocol = '0; len_in = '0; data_in = '0; ok_in = 1'b0;
    chif.ch_ready = 2'b00;
    clear_in();
    test_reset();
    test_tcp();
    test_udp_backpressure();
    test_unmatched();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
